// File: rtl/hld_pkg.sv
// hld_pkg -- shared phase enum, phase codes and state-to-code mapping for the
// highway/farm-road intersection controller and its light decoder. Rev 1.0
`default_nettype none

package hld_pkg;

  typedef enum logic [1:0] {
    NS_GREEN  = 2'd0,
    NS_YELLOW = 2'd1,
    EW_GREEN  = 2'd2,
    EW_YELLOW = 2'd3
  } phase_e;

  localparam logic [3:0] CODE_NS_GREEN  = 4'b0000;
  localparam logic [3:0] CODE_NS_YELLOW = 4'b0101;
  localparam logic [3:0] CODE_EW_GREEN  = 4'b1010;
  localparam logic [3:0] CODE_EW_YELLOW = 4'b1100;

  function automatic logic [3:0] phase_code(input phase_e p);
    logic [3:0] c;
    c = CODE_NS_GREEN;
    case (p)
      NS_GREEN:  c = CODE_NS_GREEN;
      NS_YELLOW: c = CODE_NS_YELLOW;
      EW_GREEN:  c = CODE_EW_GREEN;
      EW_YELLOW: c = CODE_EW_YELLOW;
      default:   c = CODE_NS_GREEN;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hld_controller_tick_gen.sv
// tick_gen -- prescaler producing a registered one-cycle strobe every
// TICK_DIV clocks (every clock when TICK_DIV is 1). Rev 1.0
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // tick is registered against the next count so it is high exactly while cnt == LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == LAST);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hld_controller.sv
// hld_controller -- highway/farm-road light sequencer: NS rests green and yields
// to EW on a latched request after a minimum green. Rev 1.0
`default_nettype none

module hld_controller
  import hld_pkg::*;
#(
  parameter int TICK_DIV       = 4,
  parameter int NS_MIN_GREEN   = 3,
  parameter int YELLOW_TICKS   = 2,
  parameter int EW_GREEN_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_ew,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic [1:0] phase,
  output logic       tick
);

  localparam int MAX_AB = (NS_MIN_GREEN > YELLOW_TICKS) ? NS_MIN_GREEN : YELLOW_TICKS;
  localparam int MAXP   = (MAX_AB > EW_GREEN_TICKS) ? MAX_AB : EW_GREEN_TICKS;
  localparam int TW     = $clog2(MAXP) + 1;

  localparam logic [TW-1:0] T_NS_MIN = TW'(NS_MIN_GREEN - 1);
  localparam logic [TW-1:0] T_YEL    = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] T_EW     = TW'(EW_GREEN_TICKS - 1);

  phase_e        state;
  logic [3:0]    code;
  logic [TW-1:0] timer;
  logic          req;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Later assignments win: a transition overrides the timer increment, and
  // entering EW_GREEN clears the request even if car_ew is high this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NS_GREEN;
      code  <= CODE_NS_GREEN;
      timer <= '0;
      req   <= 1'b0;
    end else begin
      if (car_ew) req <= 1'b1;
      if (tick) begin
        timer <= (timer == '1) ? timer : timer + TW'(1);
        case (state)
          NS_GREEN: if (timer >= T_NS_MIN && req) begin
            state <= NS_YELLOW;
            code  <= phase_code(NS_YELLOW);
            timer <= '0;
          end
          NS_YELLOW: if (timer == T_YEL) begin
            state <= EW_GREEN;
            code  <= phase_code(EW_GREEN);
            timer <= '0;
            req   <= 1'b0;
          end
          EW_GREEN: if (timer == T_EW) begin
            state <= EW_YELLOW;
            code  <= phase_code(EW_YELLOW);
            timer <= '0;
          end
          EW_YELLOW: if (timer == T_YEL) begin
            state <= NS_GREEN;
            code  <= phase_code(NS_GREEN);
            timer <= '0;
          end
          default: begin
            state <= NS_GREEN;
            code  <= CODE_NS_GREEN;
            timer <= '0;
          end
        endcase
      end
    end
  end

  assign {A, B, C, D} = code;
  assign phase        = state;

endmodule

`default_nettype wire

// File: doc/hld_controller.md
Name: hld_controller

Overview:
Sequential controller for the highway/farm-road intersection. It generates the 4-bit phase code {A,B,C,D} that the light decoder turns into the six lamp drives (GNS/YNS/RNS/GEW/YEW/REW). Highway (NS) rests in green. It yields to the farm road (EW) only on a latched vehicle request, after a minimum green, then runs fixed yellow and EW-green intervals. Timing is counted in ticks from an internal prescaler.

Parameters:
TICK_DIV, 4, clock cycles per timing tick (>=1)
NS_MIN_GREEN, 3, minimum NS green length in ticks (>=1)
YELLOW_TICKS, 2, length of each yellow phase in ticks (>=1)
EW_GREEN_TICKS, 4, fixed EW green length in ticks (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
car_ew  in  1  farm-road vehicle sensor; level, sampled every cycle
A  out  1  phase code bit 3
B  out  1  phase code bit 2
C  out  1  phase code bit 1
D  out  1  phase code bit 0
phase  out  2  state index: 0 NS_GREEN, 1 NS_YELLOW, 2 EW_GREEN, 3 EW_YELLOW
tick  out  1  one-cycle timing strobe, for observation

Behaviour:
- One clock; reset is synchronous and active-high. rst has priority over all other logic.
- On reset: state NS_GREEN, {A,B,C,D}=0000, phase=0, tick=0, prescaler=0, phase timer=0, request latch=0.
- Phase codes {A,B,C,D}: NS_GREEN 0000, NS_YELLOW 0101, EW_GREEN 1010, EW_YELLOW 1100. Outputs are registered and come straight from the state register, with no combinational path from car_ew.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for exactly the one cycle in which the count is TICK_DIV-1. With TICK_DIV=1, tick is high every cycle.
- Request latch: set on any cycle with car_ew=1; cleared on the clock edge that enters EW_GREEN. If car_ew=1 on that same edge, the clear wins. A vehicle still present stays high and sets the latch again on the next cycle.
- Phase timer: counts ticks elapsed in the current phase. It updates only on tick cycles: cleared to 0 on a transition, otherwise incremented and saturating at all-ones. Width is clog2 of the largest parameter, plus 1.
- Transitions are evaluated only on tick cycles. The new state is visible on the cycle after the tick.
  - NS_GREEN -> NS_YELLOW when timer >= NS_MIN_GREEN-1 and the latch is 1. Otherwise stay. A request arriving late transitions on the next tick.
  - NS_YELLOW -> EW_GREEN when timer == YELLOW_TICKS-1.
  - EW_GREEN -> EW_YELLOW when timer == EW_GREEN_TICKS-1, regardless of car_ew.
  - EW_YELLOW -> NS_GREEN when timer == YELLOW_TICKS-1.
- Resulting phase lengths are exact multiples of ticks: yellow = YELLOW_TICKS, EW green = EW_GREEN_TICKS, NS green >= NS_MIN_GREEN.
- Reset mid-phase: on the next cycle, return to NS_GREEN/0000 with prescaler, timer and latch all cleared.
- Illegal state encodings cannot be reached. The default branch recovers to NS_GREEN.

Decomposition:
- Shared package hld_pkg holds:
  - the phase enum (NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW);
  - the 4-bit phase-code constants;
  - the state-to-code function.
  The decoder and this controller both consume it.
- One sub-module, tick_gen (parameter TICK_DIV; ports clk, rst, tick), owns the prescaler.
- The FSM, timer and latch stay in hld_controller.

Test Plan:
All scenarios use default parameters. "cycle n" counts rising edges after rst deasserts.
- Reset: hold rst 3 cycles -> ABCD=0000, phase=0, tick=0. After release, tick first pulses in cycle 4, then every 4 cycles.
- No traffic: car_ew=0 for 200 cycles -> ABCD stays 0000, phase stays 0.
- Single car_ew pulse of 1 cycle at cycle 2 -> NS green holds until tick 3 (cycle 12). Then ABCD=0101 for 8 cycles, 1010 for 16 cycles, 1100 for 8 cycles, then back to 0000 with the latch clear.
- Late request: car_ew pulse at cycle 30 -> transition to 0101 after the tick at cycle 32, since minimum green is already satisfied.
- car_ew held at 1 -> continuous cycling. NS green lasts exactly 3 ticks (12 cycles); EW green always lasts 4 ticks.
- rst asserted for 1 cycle during EW_GREEN -> next cycle ABCD=0000, phase=0. The next tick follows 4 cycles after release, and there is no pending request.
